// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator arbiter and the branch unit decoder.
package cmp_pkg;

  // MIPS branch-style condition codes. Codes with bit 2 set compare against zero.
  localparam logic [2:0] CC_EQ  = 3'b000;
  localparam logic [2:0] CC_NE  = 3'b001;
  localparam logic [2:0] CC_LT  = 3'b010;
  localparam logic [2:0] CC_GE  = 3'b011;
  localparam logic [2:0] CC_LEZ = 3'b100;
  localparam logic [2:0] CC_GTZ = 3'b101;
  localparam logic [2:0] CC_LTZ = 3'b110;
  localparam logic [2:0] CC_GEZ = 3'b111;

  // Bit positions within the 3-bit comparator flag vector {A>B, A==B, A<B}.
  localparam int unsigned F_GT = 2;
  localparam int unsigned F_EQ = 1;
  localparam int unsigned F_LT = 0;

endpackage

// File: rtl/cmp32.sv
// Fixed-width 32-bit signed magnitude comparator.
module cmp32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        gt_o,
  output logic        eq_o,
  output logic        lt_o
);

  assign gt_o = $signed(a_i) >  $signed(b_i);
  assign eq_o = a_i == b_i;
  assign lt_o = $signed(a_i) <  $signed(b_i);

endmodule

// File: rtl/cmp_cond_decode.sv
// Maps a condition code and comparator flags to a taken verdict, and tells
// the datapath when the B operand must be replaced by zero.
module cmp_cond_decode
  import cmp_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic [2:0] flags_i,
  output logic       taken_o,
  output logic       b_zero_o
);

  assign b_zero_o = op_i[2];

  // Condition evaluation from the one-hot comparator flags.
  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      CC_EQ:  taken_o =  flags_i[F_EQ];
      CC_NE:  taken_o = ~flags_i[F_EQ];
      CC_LT:  taken_o =  flags_i[F_LT];
      CC_GE:  taken_o = ~flags_i[F_LT];
      CC_LEZ: taken_o =  flags_i[F_LT] | flags_i[F_EQ];
      CC_GTZ: taken_o =  flags_i[F_GT];
      CC_LTZ: taken_o =  flags_i[F_LT];
      CC_GEZ: taken_o = ~flags_i[F_LT];
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin sharing of one signed comparator between two requesters, with
// a one-entry registered response buffer per port.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  input  logic [2:0]   req_op0,
  input  logic [2:0]   req_op1,
  output logic [1:0]   resp_valid,
  input  logic [1:0]   resp_ready,
  output logic         resp_taken0,
  output logic         resp_taken1,
  output logic [2:0]   resp_flags0,
  output logic [2:0]   resp_flags1
);

  logic       last_grant_q, last_grant_d;
  logic [1:0] resp_valid_q, resp_valid_d;
  logic [1:0] taken_q, taken_d;
  logic [2:0] flags0_q, flags0_d;
  logic [2:0] flags1_q, flags1_d;

  logic [1:0]  elig;
  logic [1:0]  accept;
  logic        sel;
  logic [31:0] mux_a, mux_b, cmp_b;
  logic [2:0]  mux_op;
  logic        gt, eq, lt;
  logic [2:0]  flags;
  logic        taken;
  logic        b_zero;

  // Grant: a port is eligible when it requests and its buffer can drain;
  // a tie goes to the port that did not win the last accepted request.
  always_comb begin
    elig      = req_valid & (~resp_valid_q | resp_ready);
    req_ready = '0;
    if (rst_n) begin
      if (elig == 2'b11) req_ready = last_grant_q ? 2'b01 : 2'b10;
      else               req_ready = elig;
    end
  end

  assign accept = req_valid & req_ready;
  assign sel    = req_ready[1];

  assign mux_a  = sel ? req_a1  : req_a0;
  assign mux_b  = sel ? req_b1  : req_b0;
  assign mux_op = sel ? req_op1 : req_op0;
  assign cmp_b  = b_zero ? '0 : mux_b;

  cmp32 u_cmp (
    .a_i  (mux_a),
    .b_i  (cmp_b),
    .gt_o (gt),
    .eq_o (eq),
    .lt_o (lt)
  );

  // Flag vector assembled by named bit position.
  always_comb begin
    flags        = '0;
    flags[F_GT]  = gt;
    flags[F_EQ]  = eq;
    flags[F_LT]  = lt;
  end

  cmp_cond_decode u_dec (
    .op_i     (mux_op),
    .flags_i  (flags),
    .taken_o  (taken),
    .b_zero_o (b_zero)
  );

  // Response buffer next state: an accept overwrites, otherwise a consume clears.
  always_comb begin
    resp_valid_d = resp_valid_q;
    taken_d      = taken_q;
    flags0_d     = flags0_q;
    flags1_d     = flags1_q;
    last_grant_d = last_grant_q;
    if (accept[0]) begin
      resp_valid_d[0] = 1'b1;
      taken_d[0]      = taken;
      flags0_d        = flags;
    end else if (resp_ready[0]) begin
      resp_valid_d[0] = 1'b0;
    end
    if (accept[1]) begin
      resp_valid_d[1] = 1'b1;
      taken_d[1]      = taken;
      flags1_d        = flags;
    end else if (resp_ready[1]) begin
      resp_valid_d[1] = 1'b0;
    end
    if (|accept) last_grant_d = sel;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid_q <= '0;
      taken_q      <= '0;
      flags0_q     <= '0;
      flags1_q     <= '0;
      last_grant_q <= 1'b1;
    end else begin
      resp_valid_q <= resp_valid_d;
      taken_q      <= taken_d;
      flags0_q     <= flags0_d;
      flags1_q     <= flags1_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_taken0 = taken_q[0];
  assign resp_taken1 = taken_q[1];
  assign resp_flags0 = flags0_q;
  assign resp_flags1 = flags1_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed self-checking bench for cmp_arbiter.
module tb_cmp_arbiter;
  import cmp_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]  req_op0, req_op1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic        resp_taken0, resp_taken1;
  logic [2:0]  resp_flags0, resp_flags1;

  int vectors;
  int miscompares;

  cmp_arbiter #(.W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a0      (req_a0),
    .req_b0      (req_b0),
    .req_a1      (req_a1),
    .req_b1      (req_b1),
    .req_op0     (req_op0),
    .req_op1     (req_op1),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_taken0 (resp_taken0),
    .resp_taken1 (resp_taken1),
    .resp_flags0 (resp_flags0),
    .resp_flags1 (resp_flags1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    step();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    resp_ready = 2'b11;
    #1;
    vectors++;
    if (req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_req_ready: got %b expected 00", req_ready);
    end
    step();
    step();
    vectors++;
    if (resp_valid !== 2'b00 || resp_taken0 !== 1'b0 || resp_taken1 !== 1'b0 ||
        resp_flags0 !== 3'b000 || resp_flags1 !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b t0=%b t1=%b f0=%b f1=%b expected all zero",
               resp_valid, resp_taken0, resp_taken1, resp_flags0, resp_flags1);
    end
    req_valid = 2'b00;
    rst_n     = 1'b1;
    step();
  endtask

  task automatic test_basic();
    req_a0 = 32'd5;          req_b0 = 32'd5; req_op0 = CC_EQ;
    req_a1 = 32'hFFFF_FFFF;  req_b1 = 32'd3; req_op1 = CC_LT;
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL basic_first_grant: got %b expected 01", req_ready);
    end
    step();
    vectors++;
    if (resp_valid[0] !== 1'b1 || resp_taken0 !== 1'b1 || resp_flags0 !== 3'b010) begin
      miscompares++;
      $display("FAIL basic_port0_resp: got v=%b t=%b f=%b expected v=1 t=1 f=010",
               resp_valid[0], resp_taken0, resp_flags0);
    end
    vectors++;
    if (req_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL basic_second_grant: got %b expected 10", req_ready);
    end
    step();
    req_valid = 2'b00;
    vectors++;
    if (resp_valid !== 2'b10 || resp_taken1 !== 1'b1 || resp_flags1 !== 3'b001) begin
      miscompares++;
      $display("FAIL basic_port1_resp: got v=%b t=%b f=%b expected v=10 t=1 f=001",
               resp_valid, resp_taken1, resp_flags1);
    end
    idle();
  endtask

  task automatic test_zero_codes();
    logic [31:0] va [4];
    logic [2:0]  vop [4];
    logic        vt [4];
    logic [2:0]  vf [4];
    va[0] = 32'h8000_0000; vop[0] = CC_LTZ; vt[0] = 1'b1; vf[0] = 3'b001;
    va[1] = 32'h0000_0000; vop[1] = CC_GTZ; vt[1] = 1'b0; vf[1] = 3'b010;
    va[2] = 32'h0000_0000; vop[2] = CC_LEZ; vt[2] = 1'b1; vf[2] = 3'b010;
    va[3] = 32'h0000_0001; vop[3] = CC_GEZ; vt[3] = 1'b1; vf[3] = 3'b100;
    resp_ready = 2'b11;
    req_b0     = 32'h7FFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      req_a0    = va[i];
      req_op0   = vop[i];
      req_valid = 2'b01;
      #1;
      vectors++;
      if (req_ready !== 2'b01) begin
        miscompares++;
        $display("FAIL zero_grant[%0d]: got %b expected 01", i, req_ready);
      end
      step();
      vectors++;
      if (resp_valid[0] !== 1'b1 || resp_taken0 !== vt[i] || resp_flags0 !== vf[i]) begin
        miscompares++;
        $display("FAIL zero_resp[%0d]: got v=%b t=%b f=%b expected v=1 t=%b f=%b",
                 i, resp_valid[0], resp_taken0, resp_flags0, vt[i], vf[i]);
      end
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [31:0] pa [3];
    logic [31:0] pb [3];
    logic [2:0]  pop [3];
    logic        pt [3];
    logic [2:0]  pf [3];
    pa[0] = 32'd7; pb[0] = 32'd7; pop[0] = CC_EQ; pt[0] = 1'b1; pf[0] = 3'b010;
    pa[1] = 32'd7; pb[1] = 32'd7; pop[1] = CC_NE; pt[1] = 1'b0; pf[1] = 3'b010;
    pa[2] = 32'd2; pb[2] = 32'd9; pop[2] = CC_LT; pt[2] = 1'b1; pf[2] = 3'b001;
    req_a1 = 32'd1; req_b1 = 32'd2; req_op1 = CC_LT;
    req_valid  = 2'b10;
    resp_ready = 2'b01;
    #1;
    vectors++;
    if (req_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL bp_port1_grant: got %b expected 10", req_ready);
    end
    step();
    req_a1 = 32'd100; req_b1 = 32'd0; req_op1 = CC_EQ;
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      req_a0 = pa[i]; req_b0 = pb[i]; req_op0 = pop[i];
      #1;
      vectors++;
      if (req_ready !== 2'b01) begin
        miscompares++;
        $display("FAIL bp_grant[%0d]: got %b expected 01", i, req_ready);
      end
      step();
      vectors++;
      if (resp_valid !== 2'b11 || resp_taken1 !== 1'b1 || resp_flags1 !== 3'b001 ||
          resp_taken0 !== pt[i] || resp_flags0 !== pf[i]) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%b t1=%b f1=%b t0=%b f0=%b expected v=11 t1=1 f1=001 t0=%b f0=%b",
                 i, resp_valid, resp_taken1, resp_flags1, resp_taken0, resp_flags0, pt[i], pf[i]);
      end
    end
    req_a1 = 32'd3; req_b1 = 32'd3; req_op1 = CC_GE;
    resp_ready = 2'b11;
    #1;
    vectors++;
    if (req_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL bp_release_grant: got %b expected 10", req_ready);
    end
    step();
    vectors++;
    if (resp_valid[1] !== 1'b1 || resp_taken1 !== 1'b1 || resp_flags1 !== 3'b010) begin
      miscompares++;
      $display("FAIL bp_release_resp: got v=%b t=%b f=%b expected v=1 t=1 f=010",
               resp_valid[1], resp_taken1, resp_flags1);
    end
    idle();
  endtask

  task automatic test_fairness();
    int g0;
    int g1;
    logic [1:0] exp;
    g0 = 0;
    g1 = 0;
    req_a0 = 32'd2; req_b0 = 32'd1; req_op0 = CC_GE;
    req_a1 = 32'd1; req_b1 = 32'd2; req_op1 = CC_GE;
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int k = 0; k < 10; k++) begin
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      vectors++;
      if (req_ready !== exp) begin
        miscompares++;
        $display("FAIL fair_grant[%0d]: got %b expected %b", k, req_ready, exp);
      end
      if (req_ready == 2'b01) g0++;
      if (req_ready == 2'b10) g1++;
      step();
    end
    vectors++;
    if (g0 != 5 || g1 != 5) begin
      miscompares++;
      $display("FAIL fair_counts: got p0=%0d p1=%0d expected 5 and 5", g0, g1);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    req_a0 = 32'd4; req_b0 = 32'd9; req_op0 = CC_LT;
    req_a1 = 32'd9; req_b1 = 32'd4; req_op1 = CC_GE;
    resp_ready = 2'b00;
    req_valid  = 2'b10;
    step();
    req_valid = 2'b01;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL rmid_p0_grant: got %b expected 01", req_ready);
    end
    step();
    vectors++;
    if (resp_valid !== 2'b11) begin
      miscompares++;
      $display("FAIL rmid_both_valid: got %b expected 11", resp_valid);
    end
    rst_n     = 1'b0;
    req_valid = 2'b11;
    #1;
    vectors++;
    if (req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL rmid_req_ready: got %b expected 00", req_ready);
    end
    step();
    vectors++;
    if (resp_valid !== 2'b00 || resp_flags0 !== 3'b000 || resp_flags1 !== 3'b000) begin
      miscompares++;
      $display("FAIL rmid_cleared: got v=%b f0=%b f1=%b expected 00 000 000",
               resp_valid, resp_flags0, resp_flags1);
    end
    rst_n      = 1'b1;
    resp_ready = 2'b11;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL rmid_tie_after_reset: got %b expected 01", req_ready);
    end
    step();
    idle();
  endtask

  task automatic test_signed();
    logic [31:0] sa [4];
    logic [31:0] sb [4];
    logic [2:0]  sop [4];
    logic        st [4];
    logic [2:0]  sf [4];
    sa[0] = 32'h8000_0000; sb[0] = 32'h7FFF_FFFF; sop[0] = CC_NE; st[0] = 1'b1; sf[0] = 3'b001;
    sa[1] = 32'hFFFF_FFFF; sb[1] = 32'hFFFF_FFFF; sop[1] = CC_GE; st[1] = 1'b1; sf[1] = 3'b010;
    sa[2] = 32'h8000_0000; sb[2] = 32'h7FFF_FFFF; sop[2] = CC_LT; st[2] = 1'b1; sf[2] = 3'b001;
    sa[3] = 32'hFFFF_FFFF; sb[3] = 32'hFFFF_FFFF; sop[3] = CC_LT; st[3] = 1'b0; sf[3] = 3'b010;
    resp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      req_a0 = sa[i]; req_b0 = sb[i]; req_op0 = sop[i];
      req_valid = 2'b01;
      step();
      vectors++;
      if (resp_valid[0] !== 1'b1 || resp_taken0 !== st[i] || resp_flags0 !== sf[i]) begin
        miscompares++;
        $display("FAIL signed[%0d]: got v=%b t=%b f=%b expected v=1 t=%b f=%b",
                 i, resp_valid[0], resp_taken0, resp_flags0, st[i], sf[i]);
      end
    end
    idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n      = 1'b0;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    req_op0 = CC_EQ; req_op1 = CC_EQ;
    test_reset();
    test_basic();
    test_zero_codes();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_signed();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
